// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: width encodings,
// FSM state type and the request legality check.
package load_store_unit_pkg;

   localparam int WORD_SIZE = 32;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      DONE = 2'b11
   } lsu_state_t;

   // Returns 1 when the request is misaligned or has no legal encoding.
   // Stores only exist as B/H/W, so the unsigned widths are illegal there.
   function automatic logic lsu_req_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
      logic err_s;
      err_s = 1'b0;
      case (funct3)
         LSU_B:   err_s = 1'b0;
         LSU_H:   err_s = addr_lo[0];
         LSU_W:   err_s = (addr_lo != 2'b00);
         LSU_BU:  err_s = we;
         LSU_HU:  err_s = we | addr_lo[0];
         default: err_s = 1'b1;
      endcase
      return err_s;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory signals of the load/store unit.
// slave is the unit's own view; master is the surrounding core + memory.
interface load_store_unit_if;
   import load_store_unit_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [2:0]           req_funct3;
   logic [WORD_SIZE-1:0] req_addr;
   logic [WORD_SIZE-1:0] req_wdata;
   logic                 rsp_valid;
   logic [WORD_SIZE-1:0] rsp_rdata;
   logic                 rsp_err;
   logic                 mem_req;
   logic                 mem_we;
   logic [WORD_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic                 mem_ack;
   logic [WORD_SIZE-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  mem_ack, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      output mem_ack, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational sub-word handling: extracts and extends load data from a
// read word, and merges store byte/halfword data into a read word.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]           funct3,
   input  logic [1:0]           lane,
   input  logic [WORD_SIZE-1:0] rdata,
   input  logic [15:0]          wdata_lo,
   output logic [WORD_SIZE-1:0] load_data,
   output logic [WORD_SIZE-1:0] merged_word
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte and halfword lanes out of the read word.
   always_comb begin
      byte_s = rdata[{lane, 3'b000} +: 8];
      half_s = rdata[{lane[1], 4'b0000} +: 16];
   end

   // Sign- or zero-extend the selected lane into the load result.
   always_comb begin
      load_data = 32'h0000_0000;
      case (funct3)
         LSU_B:   load_data = {{24{byte_s[7]}}, byte_s};
         LSU_H:   load_data = {{16{half_s[15]}}, half_s};
         LSU_W:   load_data = rdata;
         LSU_BU:  load_data = {24'h00_0000, byte_s};
         LSU_HU:  load_data = {16'h0000, half_s};
         default: load_data = 32'h0000_0000;
      endcase
   end

   // Overwrite only the addressed lane; all other bytes keep the old word.
   always_comb begin
      merged_word = rdata;
      case (funct3)
         LSU_B:   merged_word[{lane, 3'b000} +: 8]     = wdata_lo[7:0];
         LSU_H:   merged_word[{lane[1], 4'b0000} +: 16] = wdata_lo;
         default: merged_word = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned memory accesses,
// sub-word loads with extension and SB/SH as read-modify-write.
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   load_store_unit_if.slave   bus
);

   lsu_state_t           state_r, state_nx;
   logic                 we_r, we_nx;
   logic [2:0]           funct3_r, funct3_nx;
   logic [1:0]           lane_r, lane_nx;
   logic [15:0]          wdata_r, wdata_nx;
   logic                 mem_req_r, mem_req_nx;
   logic                 mem_we_r, mem_we_nx;
   logic [WORD_SIZE-1:0] mem_addr_r, mem_addr_nx;
   logic [WORD_SIZE-1:0] mem_wdata_r, mem_wdata_nx;
   logic                 rsp_valid_r, rsp_valid_nx;
   logic [WORD_SIZE-1:0] rsp_rdata_r, rsp_rdata_nx;
   logic                 rsp_err_r, rsp_err_nx;
   logic [WORD_SIZE-1:0] load_data_s;
   logic [WORD_SIZE-1:0] merged_word_s;

   lsu_align u_align (
      .funct3      (funct3_r),
      .lane        (lane_r),
      .rdata       (bus.mem_rdata),
      .wdata_lo    (wdata_r),
      .load_data   (load_data_s),
      .merged_word (merged_word_s)
   );

   assign bus.req_ready = (state_r == IDLE);
   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;

   // Next-state and next-output decode; outputs are computed one cycle early
   // so that every bus output leaves the unit from a flop.
   always_comb begin
      state_nx     = state_r;
      we_nx        = we_r;
      funct3_nx    = funct3_r;
      lane_nx      = lane_r;
      wdata_nx     = wdata_r;
      mem_req_nx   = mem_req_r;
      mem_we_nx    = mem_we_r;
      mem_addr_nx  = mem_addr_r;
      mem_wdata_nx = mem_wdata_r;
      rsp_valid_nx = 1'b0;
      rsp_rdata_nx = rsp_rdata_r;
      rsp_err_nx   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.req_valid) begin
               we_nx        = bus.req_we;
               funct3_nx    = bus.req_funct3;
               lane_nx      = bus.req_addr[1:0];
               wdata_nx     = bus.req_wdata[15:0];
               mem_addr_nx  = {bus.req_addr[31:2], 2'b00};
               rsp_rdata_nx = 32'h0000_0000;
               if (lsu_req_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                  state_nx     = DONE;
                  mem_req_nx   = 1'b0;
                  rsp_valid_nx = 1'b1;
                  rsp_err_nx   = 1'b1;
               end else if (bus.req_we && (bus.req_funct3 == LSU_W)) begin
                  state_nx     = WR;
                  mem_req_nx   = 1'b1;
                  mem_we_nx    = 1'b1;
                  mem_wdata_nx = bus.req_wdata;
               end else begin
                  state_nx     = RD;
                  mem_req_nx   = 1'b1;
                  mem_we_nx    = 1'b0;
               end
            end else begin
               mem_req_nx = 1'b0;
            end
         end
         RD: begin
            if (bus.mem_ack && we_r) begin
               state_nx     = WR;
               mem_we_nx    = 1'b1;
               mem_wdata_nx = merged_word_s;
            end else if (bus.mem_ack) begin
               state_nx     = DONE;
               mem_req_nx   = 1'b0;
               rsp_valid_nx = 1'b1;
               rsp_rdata_nx = load_data_s;
            end else begin
               state_nx = RD;
            end
         end
         WR: begin
            if (bus.mem_ack) begin
               state_nx     = DONE;
               mem_req_nx   = 1'b0;
               mem_we_nx    = 1'b0;
               rsp_valid_nx = 1'b1;
            end else begin
               state_nx = WR;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx   = IDLE;
            mem_req_nx = 1'b0;
            mem_we_nx  = 1'b0;
         end
      endcase
   end

   // State, captured request and registered outputs; reset drops any
   // access in flight, so a half-done read-modify-write is never written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         we_r        <= 1'b0;
         funct3_r    <= 3'b000;
         lane_r      <= 2'b00;
         wdata_r     <= 16'h0000;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nx;
         we_r        <= we_nx;
         funct3_r    <= funct3_nx;
         lane_r      <= lane_nx;
         wdata_r     <= wdata_nx;
         mem_req_r   <= mem_req_nx;
         mem_we_r    <= mem_we_nx;
         mem_addr_r  <= mem_addr_nx;
         mem_wdata_r <= mem_wdata_nx;
         rsp_valid_r <= rsp_valid_nx;
         rsp_rdata_r <= rsp_rdata_nx;
         rsp_err_r   <= rsp_err_nx;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word memory model
// whose acknowledge latency is adjustable per test.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   load_store_unit_if bus ();

   load_store_unit u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [0:15];
   int          ack_delay  = 0;
   int          wait_cnt   = 0;
   int          write_cnt  = 0;
   logic [31:0] last_waddr = 32'h0;
   logic        pre_en     = 1'b0;
   logic [3:0]  pre_idx    = 4'h0;
   logic [31:0] pre_data   = 32'h0;

   int n_cmp = 0;
   int n_bad = 0;

   int          r_rsp_cyc, r_valid_cnt, r_req_cyc, r_ready_viol, r_stable_viol;
   logic [31:0] r_rdata, r_addr;
   logic        r_err, r_ready_after;
   int          wc;

   assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
   assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

   // Memory model: ack latency counter, writes and preloads.
   always @(posedge clk) begin
      if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
      else                             wait_cnt <= 0;
      if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
         mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
         write_cnt              <= write_cnt + 1;
         last_waddr             <= bus.mem_addr;
      end else if (pre_en) begin
         mem[pre_idx] <= pre_data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] val);
      pre_idx  = idx;
      pre_data = val;
      pre_en   = 1'b1;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   // Issue one request at a negedge in IDLE and observe it cycle by cycle
   // (cycle 0 = acceptance cycle), bounded to 20 cycles.
   task automatic do_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] ph_addr, ph_wdata;
      logic        ph_we, ph_seen;
      ph_seen = 1'b0; ph_we = 1'b0; ph_addr = 32'h0; ph_wdata = 32'h0;
      r_rsp_cyc = -1; r_valid_cnt = 0; r_req_cyc = 0; r_ready_viol = 0;
      r_stable_viol = 0; r_rdata = 32'hFFFF_FFFF; r_err = 1'b0;
      r_ready_after = 1'b0; r_addr = 32'hFFFF_FFFF;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      @(negedge clk);
      bus.req_valid  = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (bus.mem_req) begin
            r_req_cyc++;
            if (!ph_seen || (ph_we != bus.mem_we)) begin
               ph_seen  = 1'b1;
               ph_we    = bus.mem_we;
               ph_addr  = bus.mem_addr;
               ph_wdata = bus.mem_wdata;
               if (r_addr == 32'hFFFF_FFFF) r_addr = bus.mem_addr;
            end else if ((ph_addr !== bus.mem_addr) || (ph_we && (ph_wdata !== bus.mem_wdata))) begin
               r_stable_viol++;
            end
         end
         if (bus.rsp_valid) begin
            r_valid_cnt++;
            if (r_rsp_cyc < 0) begin
               r_rsp_cyc = c;
               r_rdata   = bus.rsp_rdata;
               r_err     = bus.rsp_err;
            end
         end
         if ((r_rsp_cyc >= 0) && (c == r_rsp_cyc + 1)) begin
            r_ready_after = bus.req_ready;
            break;
         end
         if ((r_rsp_cyc < 0) && bus.req_ready) r_ready_viol++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready",     {31'h0, bus.req_ready}, 32'h1);
      check_eq("rst_mem_req",   {31'h0, bus.mem_req},   32'h0);
      check_eq("rst_mem_we",    {31'h0, bus.mem_we},    32'h0);
      check_eq("rst_mem_addr",  bus.mem_addr,           32'h0);
      check_eq("rst_mem_wdata", bus.mem_wdata,          32'h0);
      check_eq("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      check_eq("rst_rsp_rdata", bus.rsp_rdata,          32'h0);
      check_eq("rst_rsp_err",   {31'h0, bus.rsp_err},   32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // LB, top byte negative
      preload(4'd0, 32'h80FF_1234);
      do_req(1'b0, LSU_B, 32'h0000_0003, 32'h0);
      check_eq("lb_cyc",   r_rsp_cyc,          32'd2);
      check_eq("lb_data",  r_rdata,            32'hFFFF_FF80);
      check_eq("lb_err",   {31'h0, r_err},     32'h0);
      check_eq("lb_addr",  r_addr,             32'h0);
      check_eq("lb_pulse", r_valid_cnt,        32'd1);
      check_eq("lb_ready", {31'h0, r_ready_after}, 32'h1);

      // LHU upper half
      preload(4'd0, 32'h8001_7FFF);
      do_req(1'b0, LSU_HU, 32'h0000_0002, 32'h0);
      check_eq("lhu_data", r_rdata, 32'h0000_8001);
      check_eq("lhu_cyc",  r_rsp_cyc, 32'd2);

      // LH lower half, sign extension
      preload(4'd0, 32'h1234_8765);
      do_req(1'b0, LSU_H, 32'h0000_0000, 32'h0);
      check_eq("lh_data", r_rdata, 32'hFFFF_8765);

      // LBU lane 1
      preload(4'd0, 32'h80FF_1234);
      do_req(1'b0, LSU_BU, 32'h0000_0001, 32'h0);
      check_eq("lbu_data", r_rdata, 32'h0000_0012);

      // LW at word 1
      preload(4'd1, 32'hA5A5_5A5A);
      do_req(1'b0, LSU_W, 32'h0000_0004, 32'h0);
      check_eq("lw_data", r_rdata, 32'hA5A5_5A5A);
      check_eq("lw_addr", r_addr,  32'h0000_0004);

      // SB read-modify-write
      preload(4'd4, 32'h1122_3344);
      wc = write_cnt;
      do_req(1'b1, LSU_B, 32'h0000_0011, 32'h0000_00AB);
      check_eq("sb_cyc",    r_rsp_cyc,       32'd3);
      check_eq("sb_mem",    mem[4],          32'h1122_AB44);
      check_eq("sb_writes", write_cnt - wc,  32'd1);
      check_eq("sb_waddr",  last_waddr,      32'h0000_0010);
      check_eq("sb_raddr",  r_addr,          32'h0000_0010);
      check_eq("sb_rdata",  r_rdata,         32'h0);
      check_eq("sb_err",    {31'h0, r_err},  32'h0);

      // SH upper half
      preload(4'd5, 32'h1122_3344);
      do_req(1'b1, LSU_H, 32'h0000_0016, 32'h1234_BEEF);
      check_eq("sh_mem", mem[5],    32'hBEEF_3344);
      check_eq("sh_cyc", r_rsp_cyc, 32'd3);

      // Misaligned LW
      do_req(1'b0, LSU_W, 32'h0000_0006, 32'h0);
      check_eq("mis_cyc",   r_rsp_cyc,      32'd1);
      check_eq("mis_err",   {31'h0, r_err}, 32'h1);
      check_eq("mis_rdata", r_rdata,        32'h0);
      check_eq("mis_memrq", r_req_cyc,      32'd0);

      // Illegal encodings and misaligned halfword
      do_req(1'b1, LSU_BU, 32'h0000_0000, 32'h0);
      check_eq("sbu_err",   {31'h0, r_err}, 32'h1);
      check_eq("sbu_memrq", r_req_cyc,      32'd0);
      do_req(1'b0, 3'b011, 32'h0000_0000, 32'h0);
      check_eq("f011_err",  {31'h0, r_err}, 32'h1);
      do_req(1'b0, LSU_H, 32'h0000_0001, 32'h0);
      check_eq("lhmis_err", {31'h0, r_err}, 32'h1);
      check_eq("lhmis_cyc", r_rsp_cyc,      32'd1);

      // SW with ack delayed 3 cycles
      ack_delay = 3;
      wc = write_cnt;
      do_req(1'b1, LSU_W, 32'h0000_0008, 32'hDEAD_BEEF);
      check_eq("sw_reqcyc", r_req_cyc,      32'd4);
      check_eq("sw_stable", r_stable_viol,  32'd0);
      check_eq("sw_ready",  r_ready_viol,   32'd0);
      check_eq("sw_cyc",    r_rsp_cyc,      32'd5);
      check_eq("sw_pulse",  r_valid_cnt,    32'd1);
      check_eq("sw_mem",    mem[2],         32'hDEAD_BEEF);
      check_eq("sw_writes", write_cnt - wc, 32'd1);
      ack_delay = 0;

      // Reset during the RD phase of an SH
      preload(4'd8, 32'hCAFE_F00D);
      ack_delay = 5;
      wc = write_cnt;
      bus.req_we     = 1'b1;
      bus.req_funct3 = LSU_H;
      bus.req_addr   = 32'h0000_0022;
      bus.req_wdata  = 32'h0000_5A5A;
      bus.req_valid  = 1'b1;
      @(negedge clk);
      bus.req_valid  = 1'b0;
      check_eq("rrd_req", {31'h0, bus.mem_req}, 32'h1);
      check_eq("rrd_we",  {31'h0, bus.mem_we},  32'h0);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("rrd_req_off", {31'h0, bus.mem_req}, 32'h0);
      rst_n = 1'b1;
      ack_delay = 0;
      @(negedge clk);
      check_eq("rrd_ready", {31'h0, bus.req_ready}, 32'h1);
      repeat (3) @(negedge clk);
      check_eq("rrd_writes", write_cnt - wc, 32'd0);
      check_eq("rrd_mem",    mem[8],         32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
